// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store bus access unit (IDLE/BUSY/DONE); optional MISALIGN_TRAP_EN
module mem_access_unit #(
    parameter int unsigned BUS_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] mem_write_data_in,
    input  logic [2:0]  funct3_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic        valid_in,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    output logic [3:0]  dbus_be,
    input  logic        dbus_ack,
    input  logic [31:0] dbus_rdata,
    output logic [31:0] load_data_out,
    output logic        load_valid_out,
    output logic        mem_err_out,
    output logic        mem_stall_out
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [15:0] TIMEOUT_LAST = 16'(BUS_TIMEOUT - 1);

    logic [1:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [1:0]  lo_q, lo_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] ld_data_q, ld_data_d;
    logic        ld_valid_q, ld_valid_d;
    logic        err_q, err_d;

    logic        access_start;
    logic        trap;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_fmt;

    assign access_start  = (state_q == ST_IDLE) && valid_in && (mem_read_in || mem_write_in);
    assign mem_stall_out = access_start || (state_q == ST_BUSY);

    // Byte-lane enables and replicated store data from access size and low address bits
    always_comb begin
        lane_be    = 4'b1111;
        lane_wdata = mem_write_data_in;
        case (funct3_in[1:0])
            2'b00: begin
                lane_be    = 4'b0001 << alu_result_in[1:0];
                lane_wdata = {4{mem_write_data_in[7:0]}};
            end
            2'b01: begin
                lane_be    = 4'b0011 << {alu_result_in[1], 1'b0};
                lane_wdata = {2{mem_write_data_in[15:0]}};
            end
            default: ;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    // Misaligned halfword/word accesses fault without touching the bus
    always_comb begin
        trap = 1'b0;
        case (funct3_in[1:0])
            2'b01:   trap = alu_result_in[0];
            2'b10:   trap = |alu_result_in[1:0];
            default: trap = 1'b0;
        endcase
    end
`else
    assign trap = 1'b0;
`endif

    // Extract and extend the addressed byte/halfword of the returned word
    always_comb begin
        case (lo_q)
            2'd0:    rd_byte = dbus_rdata[7:0];
            2'd1:    rd_byte = dbus_rdata[15:8];
            2'd2:    rd_byte = dbus_rdata[23:16];
            default: rd_byte = dbus_rdata[31:24];
        endcase
        rd_half = lo_q[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
        case (f3_q[1:0])
            2'b00:   load_fmt = {{24{rd_byte[7] & ~f3_q[2]}}, rd_byte};
            2'b01:   load_fmt = {{16{rd_half[15] & ~f3_q[2]}}, rd_half};
            default: load_fmt = dbus_rdata;
        endcase
    end

    // Next-state and registered-output logic for the access sequencer
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        lo_d       = lo_q;
        f3_d       = f3_q;
        ld_data_d  = 32'd0;
        ld_valid_d = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_d   = 1'b0;
                we_d    = 1'b0;
                addr_d  = 32'd0;
                wdata_d = 32'd0;
                be_d    = 4'd0;
                if (access_start) begin
                    lo_d  = alu_result_in[1:0];
                    f3_d  = funct3_in;
                    cnt_d = 16'd0;
                    if (trap) begin
                        state_d    = ST_DONE;
                        ld_valid_d = 1'b1;
                        err_d      = 1'b1;
                    end else begin
                        state_d = ST_BUSY;
                        req_d   = 1'b1;
                        we_d    = mem_write_in;
                        addr_d  = {alu_result_in[31:2], 2'b00};
                        wdata_d = mem_write_in ? lane_wdata : 32'd0;
                        be_d    = lane_be;
                    end
                end
            end
            ST_BUSY: begin
                if (dbus_ack || (cnt_q == TIMEOUT_LAST)) begin
                    state_d    = ST_DONE;
                    ld_valid_d = 1'b1;
                    err_d      = ~dbus_ack;
                    ld_data_d  = (dbus_ack && !we_q) ? load_fmt : 32'd0;
                    req_d      = 1'b0;
                    we_d       = 1'b0;
                    addr_d     = 32'd0;
                    wdata_d    = 32'd0;
                    be_d       = 4'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 16'd0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            be_q       <= 4'd0;
            lo_q       <= 2'd0;
            f3_q       <= 3'd0;
            ld_data_q  <= 32'd0;
            ld_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            lo_q       <= lo_d;
            f3_q       <= f3_d;
            ld_data_q  <= ld_data_d;
            ld_valid_q <= ld_valid_d;
            err_q      <= err_d;
        end
    end

    assign dbus_req       = req_q;
    assign dbus_we        = we_q;
    assign dbus_addr      = addr_q;
    assign dbus_wdata     = wdata_q;
    assign dbus_be        = be_q;
    assign load_data_out  = ld_data_q;
    assign load_valid_out = ld_valid_q;
    assign mem_err_out    = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit
module tb_mem_access_unit;

    logic        clk;
    logic        reset;
    logic [31:0] alu_result_in;
    logic [31:0] mem_write_data_in;
    logic [2:0]  funct3_in;
    logic        mem_read_in;
    logic        mem_write_in;
    logic        valid_in;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [31:0] dbus_wdata;
    logic [3:0]  dbus_be;
    logic        dbus_ack;
    logic [31:0] dbus_rdata;
    logic [31:0] load_data_out;
    logic        load_valid_out;
    logic        mem_err_out;
    logic        mem_stall_out;

    mem_access_unit #(.BUS_TIMEOUT(4)) dut (
        .clk               (clk),
        .reset             (reset),
        .alu_result_in     (alu_result_in),
        .mem_write_data_in (mem_write_data_in),
        .funct3_in         (funct3_in),
        .mem_read_in       (mem_read_in),
        .mem_write_in      (mem_write_in),
        .valid_in          (valid_in),
        .dbus_req          (dbus_req),
        .dbus_we           (dbus_we),
        .dbus_addr         (dbus_addr),
        .dbus_wdata        (dbus_wdata),
        .dbus_be           (dbus_be),
        .dbus_ack          (dbus_ack),
        .dbus_rdata        (dbus_rdata),
        .load_data_out     (load_data_out),
        .load_valid_out    (load_valid_out),
        .mem_err_out       (mem_err_out),
        .mem_stall_out     (mem_stall_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    logic        chk;
    logic        e_req, e_we, e_stall, e_valid, e_err;
    logic [31:0] e_addr, e_wdata, e_data;
    logic [3:0]  e_be;
    logic        lit_be_en, lit_d_en;
    logic [3:0]  lit_be;
    logic [31:0] lit_d;

    // Reference model: what a size/address/data combination must produce on the bus
    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        if (f3[1:0] == 2'b00) return 4'(1 << (a % 4));
        if (f3[1:0] == 2'b01) return 4'(3 << (a & 2));
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
        if (f3[1:0] == 2'b00) return (d & 32'hFF) * 32'h01010101;
        if (f3[1:0] == 2'b01) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
        logic [31:0] v;
        if (f3[1:0] == 2'b00) begin
            v = (w >> (8 * (a % 4))) & 32'hFF;
            if (!f3[2] && v >= 32'h80) v = v + 32'hFFFFFF00;
            return v;
        end
        if (f3[1:0] == 2'b01) begin
            v = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
            if (!f3[2] && v >= 32'h8000) v = v + 32'hFFFF0000;
            return v;
        end
        return w;
    endfunction

    function automatic logic m_trap(input logic [2:0] f3, input logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
        return (f3[1:0] == 2'b01 && (a % 2) != 0) || (f3[1:0] == 2'b10 && (a % 4) != 0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Single compare process: every checked cycle, all outputs against the model
    always @(negedge clk) begin
        if (chk) begin
            cmp("dbus_req",       {31'd0, dbus_req},       {31'd0, e_req});
            cmp("dbus_we",        {31'd0, dbus_we},        {31'd0, e_we});
            cmp("dbus_addr",      dbus_addr,               e_addr);
            cmp("dbus_wdata",     dbus_wdata,              e_wdata);
            cmp("dbus_be",        {28'd0, dbus_be},        {28'd0, e_be});
            cmp("mem_stall_out",  {31'd0, mem_stall_out},  {31'd0, e_stall});
            cmp("load_valid_out", {31'd0, load_valid_out}, {31'd0, e_valid});
            cmp("mem_err_out",    {31'd0, mem_err_out},    {31'd0, e_err});
            cmp("load_data_out",  load_data_out,           e_data);
            if (lit_be_en) cmp("literal_be", {28'd0, dbus_be}, {28'd0, lit_be});
            if (lit_d_en)  cmp("literal_load_data", load_data_out, lit_d);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exp(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] be, input logic stall, input logic vld, input logic err,
                           input logic [31:0] data);
        e_req = req; e_we = we; e_addr = addr; e_wdata = wd; e_be = be;
        e_stall = stall; e_valid = vld; e_err = err; e_data = data;
    endtask

    task automatic idle(input int n, input logic rd_wr_noise);
        for (int i = 0; i < n; i++) begin
            valid_in = 1'b0; mem_read_in = rd_wr_noise; mem_write_in = rd_wr_noise;
            dbus_ack = 1'b0; dbus_rdata = 32'hDEADBEEF;
            lit_be_en = 1'b0; lit_d_en = 1'b0;
            set_exp(0, 0, 0, 0, 0, 0, 0, 0, 0);
            step();
        end
        mem_read_in = 1'b0; mem_write_in = 1'b0;
    endtask

    // One access: accept cycle, BUSY cycles until ack_at (0 = never), DONE cycle
    task automatic access(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] word, input int ack_at,
                          input logic lbe_en, input logic [3:0] lbe, input logic ld_en, input logic [31:0] ld);
        logic acked;
        valid_in = 1'b1; mem_read_in = rd; mem_write_in = wr; funct3_in = f3;
        alu_result_in = a; mem_write_data_in = d;
        dbus_ack = 1'b0; dbus_rdata = 32'hDEADBEEF;
        lit_be_en = 1'b0; lit_d_en = 1'b0;
        set_exp(0, 0, 0, 0, 0, 1, 0, 0, 0);
        step();
        if (m_trap(f3, a)) begin
            set_exp(0, 0, 0, 0, 0, 0, 1, 1, 0);
            step();
            return;
        end
        acked = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            dbus_ack   = (k == ack_at);
            dbus_rdata = (k == ack_at) ? word : 32'hDEADBEEF;
            lit_be_en  = lbe_en; lit_be = lbe;
            set_exp(1, wr, a & 32'hFFFFFFFC, wr ? m_wdata(f3, d) : 32'd0, m_be(f3, a), 1, 0, 0, 0);
            step();
            if (k == ack_at) begin
                acked = 1'b1;
                break;
            end
        end
        dbus_ack = 1'b0; dbus_rdata = 32'hDEADBEEF;
        lit_be_en = 1'b0; lit_d_en = ld_en; lit_d = ld;
        set_exp(0, 0, 0, 0, 0, 0, 1, !acked, (acked && !wr) ? m_load(f3, a, word) : 32'd0);
        step();
        lit_d_en = 1'b0;
    endtask

    initial begin
        reset = 1'b1; valid_in = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0;
        funct3_in = 3'd0; alu_result_in = 32'd0; mem_write_data_in = 32'd0;
        dbus_ack = 1'b0; dbus_rdata = 32'd0;
        chk = 1'b0; lit_be_en = 1'b0; lit_d_en = 1'b0; lit_be = 4'd0; lit_d = 32'd0;
        set_exp(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        chk = 1'b1;
        step();
        reset = 1'b0;
        idle(2, 1'b0);

        // SB 0x103, ack on third BUSY cycle
        access(0, 1, 3'b000, 32'h103, 32'h000000A5, 32'd0, 3, 1, 4'b1000, 0, 0);
        idle(1, 1'b0);
        // LB / LBU / LHU from 0x202
        access(1, 0, 3'b000, 32'h202, 32'd0, 32'h0080FF00, 1, 1, 4'b0100, 1, 32'hFFFFFF80);
        idle(1, 1'b0);
        access(1, 0, 3'b100, 32'h202, 32'd0, 32'h0080FF00, 1, 0, 0, 1, 32'h00000080);
        idle(1, 1'b0);
        access(1, 0, 3'b101, 32'h202, 32'd0, 32'h0080FF00, 1, 1, 4'b1100, 1, 32'h00000080);
        idle(1, 1'b0);
        // LH sign-extend low half, SH upper half
        access(1, 0, 3'b001, 32'h200, 32'd0, 32'h12348001, 2, 0, 0, 1, 32'hFFFF8001);
        idle(1, 1'b0);
        access(0, 1, 3'b001, 32'h302, 32'h1234ABCD, 32'd0, 1, 1, 4'b1100, 0, 0);
        idle(1, 1'b0);
        // LW timeout, then LW with ack on the last allowed cycle
        access(1, 0, 3'b010, 32'h400, 32'd0, 32'h11223344, 0, 1, 4'b1111, 1, 32'd0);
        idle(1, 1'b0);
        access(1, 0, 3'b010, 32'h400, 32'd0, 32'h11223344, 4, 1, 4'b1111, 1, 32'h11223344);
        idle(1, 1'b0);
        // Misaligned SW and LH
        access(0, 1, 3'b010, 32'h102, 32'hCAFEF00D, 32'd0, 1, 1, 4'b1111, 0, 0);
        idle(1, 1'b0);
        access(1, 0, 3'b001, 32'h201, 32'd0, 32'h00FF7F00, 1, 0, 0, 0, 0);
        idle(1, 1'b0);
        // Read and write both set: store
        access(1, 1, 3'b010, 32'h500, 32'h89ABCDEF, 32'h55555555, 1, 0, 0, 1, 32'd0);
        // valid_in low with read/write asserted: nothing happens
        idle(3, 1'b1);

        // Reset in second BUSY cycle of an LW
        valid_in = 1'b1; mem_read_in = 1'b1; mem_write_in = 1'b0; funct3_in = 3'b010;
        alu_result_in = 32'h600; dbus_ack = 1'b0; dbus_rdata = 32'hDEADBEEF;
        set_exp(0, 0, 0, 0, 0, 1, 0, 0, 0);
        step();
        set_exp(1, 0, 32'h600, 0, 4'hF, 1, 0, 0, 0);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        idle(4, 1'b0);
        access(1, 0, 3'b010, 32'h604, 32'd0, 32'hA5A55A5A, 1, 0, 0, 1, 32'hA5A55A5A);

        // Back-to-back LWs
        idle(1, 1'b0);
        access(1, 0, 3'b010, 32'h700, 32'd0, 32'h01020304, 1, 0, 0, 1, 32'h01020304);
        access(1, 0, 3'b010, 32'h704, 32'd0, 32'hF0E0D0C0, 1, 0, 0, 1, 32'hF0E0D0C0);
        idle(2, 1'b0);

        chk = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
